// File: rtl/change_return_sequencer_pkg.sv
// Shared sizing, default coin table and FSM state encoding for the change-return path.
package change_return_sequencer_pkg;

  localparam int unsigned kNumCoins  = 3;
  localparam int unsigned kTotalBits = 31;
  localparam int unsigned kWaitTime  = 100;
  localparam int unsigned kStockBits = 8;
  localparam int unsigned kStockInit = 4;
  localparam int unsigned kCoinW     = 32;

  localparam logic [kNumCoins*kCoinW-1:0] kCoinValueDefault = {32'd1000, 32'd500, 32'd100};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SELECT = 3'd2,
    EJECT  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/change_coin_picker.sv
// Greedy selector: highest available denomination that does not exceed the remaining amount.
module change_coin_picker
  import change_return_sequencer_pkg::*;
#(
  parameter int unsigned NUM_COINS  = kNumCoins,
  parameter int unsigned TOTAL_BITS = kTotalBits
) (
  input  logic [TOTAL_BITS-1:0]       i_remaining,
  input  logic [NUM_COINS*kCoinW-1:0] i_coin_value,
  input  logic [NUM_COINS-1:0]        i_avail,
  output logic [NUM_COINS-1:0]        o_idx_c,
  output logic                        o_found_c
);

  localparam int unsigned CMP_W = (TOTAL_BITS > kCoinW) ? TOTAL_BITS : kCoinW;

  // Ascending scan so the last qualifying (largest) index wins.
  always_comb begin
    o_idx_c   = '0;
    o_found_c = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_avail[i] &&
          (CMP_W'(i_coin_value[i*kCoinW +: kCoinW]) <= CMP_W'(i_remaining))) begin
        o_idx_c    = '0;
        o_idx_c[i] = 1'b1;
        o_found_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_return_sequencer.sv
// Change-return controller: inactivity timer, greedy coin ejection and balance debit.
// Build option CHANGE_STOCK_EN adds per-denomination stock counters that gate selection.
module change_return_sequencer
  import change_return_sequencer_pkg::*;
#(
  parameter int unsigned NUM_COINS  = kNumCoins,
  parameter int unsigned TOTAL_BITS = kTotalBits,
  parameter int unsigned WAIT_TIME  = kWaitTime,
  parameter int unsigned STOCK_BITS = kStockBits,
  parameter int unsigned STOCK_INIT = kStockInit
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_COINS*kCoinW-1:0] coin_value,
  input  logic [TOTAL_BITS-1:0]       i_balance,
  input  logic                        i_activity,
  input  logic [NUM_COINS-1:0]        i_coin_insert,
  input  logic                        i_return_req,
  input  logic                        i_eject_ready,
  output logic                        o_eject_valid,
  output logic [NUM_COINS-1:0]        o_eject_idx,
  output logic                        o_debit_valid,
  output logic [TOTAL_BITS-1:0]       o_debit_amount,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [TOTAL_BITS-1:0]       o_shortfall
);

  localparam int unsigned TIMER_W = (WAIT_TIME < 1) ? 1 : $clog2(WAIT_TIME + 1);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [TIMER_W-1:0]      r_timer;
  logic [TOTAL_BITS-1:0]   r_remaining;
  logic [NUM_COINS-1:0]    r_eject_idx;
  logic [TOTAL_BITS-1:0]   r_shortfall;
  logic [NUM_COINS-1:0]    w_avail;
  logic [NUM_COINS-1:0]    w_pick_idx;
  logic                    w_found;
  logic                    w_handshake;
  logic                    w_enter_select;
  logic [kCoinW-1:0]       w_coin_sel;
  logic [TOTAL_BITS-1:0]   w_debit;

  change_coin_picker #(
    .NUM_COINS  (NUM_COINS),
    .TOTAL_BITS (TOTAL_BITS)
  ) u_picker (
    .i_remaining  (r_remaining),
    .i_coin_value (coin_value),
    .i_avail      (w_avail),
    .o_idx_c      (w_pick_idx),
    .o_found_c    (w_found)
  );

  // Reset gates the handshake so an aborted offer never debits.
  assign w_handshake    = (r_state == EJECT) && i_eject_ready && !reset;
  assign w_enter_select = ((r_state == IDLE) || (r_state == ARMED)) && (w_state_next == SELECT);
  assign w_debit        = TOTAL_BITS'(w_coin_sel);

  always_comb begin
    w_coin_sel = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (r_eject_idx[i]) w_coin_sel = w_coin_sel | coin_value[i*kCoinW +: kCoinW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Return request beats activity; in ARMED activity also holds off a pending timeout.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_return_req)    w_state_next = SELECT;
        else if (i_activity) w_state_next = ARMED;
      end
      ARMED: begin
        if (i_return_req)                         w_state_next = SELECT;
        else if (!i_activity && (r_timer == '0))  w_state_next = SELECT;
      end
      SELECT:  w_state_next = w_found ? EJECT : DONE;
      EJECT:   if (w_handshake) w_state_next = SELECT;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_eject_valid  = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_debit_valid  = 1'b0;
    o_debit_amount = '0;
    unique case (r_state)
      SELECT: o_busy = 1'b1;
      EJECT: begin
        o_busy        = 1'b1;
        o_eject_valid = 1'b1;
        if (w_handshake) begin
          o_debit_valid  = 1'b1;
          o_debit_amount = w_debit;
        end
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_eject_idx = r_eject_idx;
  assign o_shortfall = r_shortfall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == DONE) begin
      r_timer <= '0;
    end else if (((r_state == IDLE) || (r_state == ARMED)) && i_activity && !i_return_req) begin
      r_timer <= TIMER_W'(WAIT_TIME);
    end else if ((r_state == ARMED) && (r_timer != '0)) begin
      r_timer <= r_timer - TIMER_W'(1);
    end
  end

  // Remaining amount, offered coin and shortfall of the current return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_eject_idx <= '0;
      r_shortfall <= '0;
    end else begin
      if (w_enter_select) begin
        r_remaining <= i_balance;
        r_shortfall <= '0;
      end else if (w_handshake) begin
        r_remaining <= r_remaining - w_debit;
      end
      if (r_state == SELECT) begin
        if (w_found) r_eject_idx <= w_pick_idx;
        else         r_shortfall <= r_remaining;
      end else if (w_handshake) begin
        r_eject_idx <= '0;
      end
    end
  end

`ifdef CHANGE_STOCK_EN
  logic [STOCK_BITS-1:0] r_stock [NUM_COINS];

  // Insert and eject of one index in the same cycle cancel; inserts saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COINS; i++) r_stock[i] <= STOCK_BITS'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (i_coin_insert[i] && !(w_handshake && r_eject_idx[i])) begin
          if (r_stock[i] != '1) r_stock[i] <= r_stock[i] + STOCK_BITS'(1);
        end else if (!i_coin_insert[i] && w_handshake && r_eject_idx[i]) begin
          r_stock[i] <= r_stock[i] - STOCK_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    w_avail = '0;
    for (int i = 0; i < NUM_COINS; i++) w_avail[i] = (r_stock[i] != '0);
  end
`else
  logic w_unused_stock;

  assign w_avail        = '1;
  assign w_unused_stock = ^{i_coin_insert, STOCK_BITS'(STOCK_INIT)};
`endif

endmodule

// File: tb/tb_change_return_sequencer.sv
// Bench for change_return_sequencer: vector table, timing corner cases, random vs. reference model.
module tb_change_return_sequencer;

  localparam int unsigned NC = 3;
  localparam int unsigned TB = 31;
  localparam int unsigned WT = 5;
`ifdef CHANGE_STOCK_EN
  localparam bit STOCK_ON = 1'b1;
`else
  localparam bit STOCK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NC*32-1:0] coin_value;
  logic [TB-1:0]   i_balance;
  logic            i_activity;
  logic [NC-1:0]   i_coin_insert;
  logic            i_return_req;
  logic            i_eject_ready;
  logic            o_eject_valid;
  logic [NC-1:0]   o_eject_idx;
  logic            o_debit_valid;
  logic [TB-1:0]   o_debit_amount;
  logic            o_busy;
  logic            o_done;
  logic [TB-1:0]   o_shortfall;

  always #5 clk = ~clk;

  change_return_sequencer #(
    .NUM_COINS  (NC),
    .TOTAL_BITS (TB),
    .WAIT_TIME  (WT),
    .STOCK_BITS (8),
    .STOCK_INIT (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .coin_value     (coin_value),
    .i_balance      (i_balance),
    .i_activity     (i_activity),
    .i_coin_insert  (i_coin_insert),
    .i_return_req   (i_return_req),
    .i_eject_ready  (i_eject_ready),
    .o_eject_valid  (o_eject_valid),
    .o_eject_idx    (o_eject_idx),
    .o_debit_valid  (o_debit_valid),
    .o_debit_amount (o_debit_amount),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_shortfall    (o_shortfall)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cv[3]   = '{100, 500, 1000};
  int q_idx[$];

  typedef struct {
    int bal;
    int total;
    int n;
    int shortv;
  } vec_t;
  vec_t vecs[8];

  // Reference model state
  typedef enum int {P_IDLE, P_ARMED, P_PICK, P_OFFER, P_END} phase_e;
  phase_e m_phase;
  int m_timer, m_rem, m_short, m_coin;
  int m_stock[3];

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; i_activity = 1'b0; i_return_req = 1'b0;
    i_coin_insert = '0; i_eject_ready = 1'b0; i_balance = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic do_return(input int bal, output int n, output int total,
                           output int shortv, output int first_valid);
    bit got_done;
    n = 0; total = 0; shortv = -1; first_valid = -1; got_done = 1'b0;
    q_idx.delete();
    i_balance = TB'(bal); i_eject_ready = 1'b1; i_return_req = 1'b1;
    step();
    i_return_req = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      #1;
      if (o_eject_valid && first_valid < 0) first_valid = c;
      if (o_debit_valid) begin
        n++;
        total += int'(o_debit_amount);
        q_idx.push_back(int'(o_eject_idx));
      end
      if (o_done) begin
        got_done = 1'b1;
        shortv = int'(o_shortfall);
      end
      step();
    end
    check($sformatf("return_%0d_finished", bal), longint'(got_done), 1);
  endtask

  task automatic timed_start(input int second_act, output int k_busy, output int k_valid);
    k_busy = -1; k_valid = -1;
    i_balance = TB'(500); i_eject_ready = 1'b1; i_activity = 1'b1;
    step();
    for (int k = 1; k <= 40 && k_valid < 0; k++) begin
      i_activity = (k == second_act);
      step();
      if (o_busy && k_busy < 0) k_busy = k;
      if (o_eject_valid) k_valid = k;
    end
    i_activity = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_timer = 0; m_rem = 0; m_short = 0; m_coin = 0;
    for (int i = 0; i < 3; i++) m_stock[i] = 4;
  endtask

  task automatic model_start();
    m_rem = int'(i_balance); m_short = 0; m_phase = P_PICK;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int ej, pick, nv;
    ej = -1; pick = -1;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (i_return_req) model_start();
        else if (i_activity) begin m_timer = WT; m_phase = P_ARMED; end
      end
      P_ARMED: begin
        if (i_return_req) model_start();
        else if (i_activity) m_timer = WT;
        else if (m_timer == 0) model_start();
        else m_timer--;
      end
      P_PICK: begin
        for (int i = int'(NC) - 1; i >= 0 && pick < 0; i--)
          if (cv[i] <= m_rem && (!STOCK_ON || m_stock[i] > 0)) pick = i;
        if (pick >= 0) begin m_coin = pick; m_phase = P_OFFER; end
        else begin m_short = m_rem; m_phase = P_END; end
      end
      P_OFFER: begin
        if (i_eject_ready) begin m_rem -= cv[m_coin]; ej = m_coin; m_phase = P_PICK; end
      end
      default: begin m_timer = 0; m_phase = P_IDLE; end
    endcase
    if (STOCK_ON) begin
      for (int i = 0; i < 3; i++) begin
        nv = m_stock[i] + int'(i_coin_insert[i]) - ((ej == i) ? 1 : 0);
        m_stock[i] = (nv > 255) ? 255 : nv;
      end
    end
  endtask

  initial begin
    int n, tot, sh, fv, kb, kv;
    int ord_exp[3];
    logic e_valid, e_dv, e_busy, e_done;
    logic [NC-1:0] e_idx;
    logic [TB-1:0] e_amt, e_short;

    coin_value = {32'd1000, 32'd500, 32'd100};
    ord_exp = '{4, 2, 1};
    vecs[0] = '{1600, 1600, 3, 0};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{50, 0, 0, 50};
    vecs[3] = '{2750, 2700, 5, 50};
    vecs[4] = '{600, 600, 2, 0};
    vecs[5] = '{4000, 4000, 4, 0};
    vecs[6] = '{5000, 5000, STOCK_ON ? 6 : 5, 0};
    vecs[7] = '{7000, STOCK_ON ? 6400 : 7000, STOCK_ON ? 12 : 7, STOCK_ON ? 600 : 0};

    apply_reset();
    #1;
    check("reset_ctl", {o_eject_valid, o_eject_idx, o_debit_valid, o_busy, o_done}, 0);
    check("reset_amt", {o_debit_amount, o_shortfall}, 0);

    for (int v = 0; v < 8; v++) begin
      apply_reset();
      do_return(vecs[v].bal, n, tot, sh, fv);
      check($sformatf("vec%0d_count", v), n, vecs[v].n);
      check($sformatf("vec%0d_total", v), tot, vecs[v].total);
      check($sformatf("vec%0d_short", v), sh, vecs[v].shortv);
      if (vecs[v].n > 0) check($sformatf("vec%0d_latency", v), fv, 1);
    end

    // Largest-first ordering
    apply_reset();
    do_return(1600, n, tot, sh, fv);
    check("order_size", q_idx.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("order_%0d", i), q_idx[i], ord_exp[i]);

    // Inactivity timeout and timer reload
    apply_reset();
    timed_start(-1, kb, kv);
    check("timeout_select_edge", kb, 6);
    check("timeout_eject_edge", kv, 7);
    #1;
    check("timeout_idx", o_eject_idx, 3'b010);
    check("timeout_debit", {o_debit_valid, o_debit_amount}, {1'b1, 31'd500});
    apply_reset();
    timed_start(3, kb, kv);
    check("reload_select_edge", kb, 9);
    check("reload_eject_edge", kv, 10);

    // Ejector back-pressure
    apply_reset();
    i_balance = TB'(500); i_eject_ready = 1'b0; i_return_req = 1'b1;
    step();
    i_return_req = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_offer", k), {o_eject_valid, o_eject_idx}, {1'b1, 3'b010});
      check($sformatf("stall%0d_nodebit", k), o_debit_valid, 0);
      step();
    end
    i_eject_ready = 1'b1;
    #1;
    check("stall_release_debit", {o_debit_valid, o_debit_amount}, {1'b1, 31'd500});
    step(); step();
    check("stall_done", {o_done, o_shortfall}, {1'b1, 31'd0});

    // Stock exhaustion of denomination 1, then of denomination 0, then refill
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      do_return(500, n, tot, sh, fv);
      check($sformatf("drain500_%0d", r), n, 1);
    end
    do_return(600, n, tot, sh, fv);
    check("s600_count", n, STOCK_ON ? 4 : 2);
    check("s600_short", sh, STOCK_ON ? 200 : 0);
    do_return(100, n, tot, sh, fv);
    check("s100_count", n, STOCK_ON ? 0 : 1);
    check("s100_short", sh, STOCK_ON ? 100 : 0);
    i_coin_insert = 3'b001;
    step();
    i_coin_insert = '0;
    do_return(100, n, tot, sh, fv);
    check("refill_count", n, 1);
    check("refill_short", sh, 0);

    // Reset while a coin is offered
    apply_reset();
    do_return(1000, n, tot, sh, fv);
    check("pre_abort_count", n, 1);
    i_balance = TB'(1000); i_eject_ready = 1'b0; i_return_req = 1'b1;
    step();
    i_return_req = 1'b0;
    step();
    check("abort_offer_up", o_eject_valid, 1);
    reset = 1'b1; i_eject_ready = 1'b1;
    #1;
    check("abort_no_debit", o_debit_valid, 0);
    step();
    reset = 1'b0;
    #1;
    check("abort_ctl_zero", {o_eject_valid, o_eject_idx, o_debit_valid, o_busy, o_done}, 0);
    check("abort_amt_zero", {o_debit_amount, o_shortfall}, 0);
    do_return(5000, n, tot, sh, fv);
    check("post_abort_count", n, STOCK_ON ? 6 : 5);
    check("post_abort_total", tot, 5000);

    // Random traffic against the reference model
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset         = ($urandom_range(0, 499) == 0);
      i_activity    = ($urandom_range(0, 19) == 0);
      i_return_req  = ($urandom_range(0, 39) == 0);
      i_eject_ready = ($urandom_range(0, 9) < 6);
      i_coin_insert = ($urandom_range(0, 9) == 0) ? NC'(1 << $urandom_range(0, 2)) : '0;
      i_balance     = TB'($urandom_range(0, 60) * 50);
      #1;
      e_valid = (m_phase == P_OFFER);
      e_idx   = e_valid ? NC'(1 << m_coin) : '0;
      e_dv    = e_valid && i_eject_ready && !reset;
      e_amt   = e_dv ? TB'(cv[m_coin]) : '0;
      e_busy  = (m_phase == P_PICK) || (m_phase == P_OFFER);
      e_done  = (m_phase == P_END);
      e_short = TB'(m_short);
      check($sformatf("rand%0d_ctl", cyc),
            {o_eject_valid, o_eject_idx, o_debit_valid, o_busy, o_done},
            {e_valid, e_idx, e_dv, e_busy, e_done});
      check($sformatf("rand%0d_amt", cyc), {o_debit_amount, o_shortfall}, {e_amt, e_short});
      model_step();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
